// File: rtl/seq_mult16_signed.sv
// Multi-cycle shift-add multiplier, signed or unsigned per operation.
// Signed operands become magnitudes; the product is negated at the end.
module seq_mult16_signed #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               sgn,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sgn;
  logic               r_neg;
  logic [2*WIDTH:0]   r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_addend;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_last;

  assign w_mag_a = (r_sgn & r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mag_b = (r_sgn & r_b[WIDTH-1]) ? -r_b : r_b;

  // Only add the multiplicand when the multiplier LSB is set
  assign w_addend = r_acc[0] ? {1'b0, r_a} : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
  assign w_prod   = r_acc[2*WIDTH-1:0];
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: w_next = S_MUL;
      S_MUL:  if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_LOAD, S_MUL, S_FIX: busy = 1'b1;
      S_DONE:               done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
      r_neg <= 1'b0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_sgn <= sgn;
          end
        end
        S_LOAD: begin
          r_a   <= w_mag_a;
          r_neg <= r_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          // Multiplier rides in the low half and shifts out as it is used
          r_acc <= {{(WIDTH+1){1'b0}}, w_mag_b};
          r_cnt <= '0;
        end
        S_MUL: begin
          r_acc <= {1'b0, w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_p <= r_neg ? -w_prod : w_prod;
        end
        default: ;
      endcase
    end
  end

  assign P = r_p;

endmodule

// File: tb/tb_seq_mult16_signed.sv
// Random and directed checks of seq_mult16_signed against a plain
// arithmetic product model.
module tb_seq_mult16_signed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        sgn;
  logic        busy;
  logic        done;
  logic [31:0] P;

  int n_cmp = 0;
  int n_err = 0;

  seq_mult16_signed #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .sgn   (sgn),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s);
    longint pa;
    longint pb;
    longint pr;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    pr = pa * pb;
    return pr[31:0];
  endfunction

  task automatic run_op(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic s);
    int lat;
    int nb;
    bit got;
    @(negedge clk);
    A = a; B = b; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    sgn = 1'($urandom);
    lat = 0; nb = 0; got = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (busy) nb++;
      if (done) begin
        got = 1;
        lat = k;
      end
      if (!got) @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(lat), 32'd19);
    chk({tag, "_busy"}, 32'(nb), 32'd18);
    chk({tag, "_P"}, P, ref_mul(a, b, s));
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0;
    A = '0; B = '0; sgn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_P", P, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", 32'(nd), 32'd0);

    run_op("umax", 16'hFFFF, 16'hFFFF, 1'b0);
    chk("umax_val", P, 32'hFFFE0001);
    run_op("s_m5x7", 16'hFFFB, 16'h0007, 1'b1);
    chk("s_m5x7_val", P, 32'hFFFFFFDD);
    run_op("s_mnmn", 16'h8000, 16'h8000, 1'b1);
    chk("s_mnmn_val", P, 32'h40000000);
    run_op("s_mnx1", 16'h8000, 16'h0001, 1'b1);
    chk("s_mnx1_val", P, 32'hFFFF8000);
    run_op("s_zero", 16'hFFFB, 16'h0000, 1'b1);
    chk("s_zero_val", P, 32'h0);
    run_op("u_zero", 16'hFFFB, 16'h0000, 1'b0);

    // second start while busy must be dropped
    @(negedge clk);
    A = 16'd3; B = 16'd4; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        A = 16'd9; B = 16'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) nd++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_pulses", 32'(nd), 32'd1);
    chk("ign_P", P, 32'h0000000C);
    run_op("fresh", 16'd9, 16'd9, 1'b0);
    chk("fresh_val", P, 32'h00000051);

    // reset in the middle of an operation
    @(negedge clk);
    A = 16'h1234; B = 16'h0010; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_P", P, 32'h0);
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_done", 32'(nd), 32'd0);
    run_op("post", 16'h1234, 16'h0010, 1'b0);
    chk("post_val", P, 32'h00012340);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 16'($urandom),
             16'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
